// File: rtl/reg_busy_table.sv
// Register busy-bit scoreboard: issue ports mark destinations busy, writeback ports free them,
// query ports read busy state combinationally with same-cycle clear bypass. State updates 1 cycle after request; no backpressure.
module reg_busy_table #(
    parameter int NUM_REGS       = 32,
    parameter int IDX_W          = $clog2(NUM_REGS),
    parameter int SET_PORTS      = 2,
    parameter int CLR_PORTS      = 2,
    parameter int RD_PORTS       = 4,
    parameter int ZERO_HARDWIRED = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush,
    input  logic [SET_PORTS-1:0]              set_valid,
    input  logic [SET_PORTS*IDX_W-1:0]        set_idx,
    input  logic [CLR_PORTS-1:0]              clr_valid,
    input  logic [CLR_PORTS*IDX_W-1:0]        clr_idx,
    input  logic [RD_PORTS*IDX_W-1:0]         rd_idx,
    output logic [RD_PORTS-1:0]               rd_busy,
    output logic [NUM_REGS-1:0]               busy_vec,
    output logic [$clog2(NUM_REGS+1)-1:0]     busy_count,
    output logic                              err_dup_set,
    output logic                              err_set_busy,
    output logic                              err_range
);

    localparam int CNT_W = $clog2(NUM_REGS + 1);

    logic [NUM_REGS-1:0] r_busy_vec;
    logic [CNT_W-1:0]    r_busy_count;
    logic                r_err_dup_set;
    logic                r_err_set_busy;
    logic                r_err_range;

    logic [NUM_REGS-1:0] w_set_port [SET_PORTS];
    logic [NUM_REGS-1:0] w_set_mask;
    logic [NUM_REGS-1:0] w_clr_mask;
    logic [NUM_REGS-1:0] w_busy_next;
    logic [CNT_W-1:0]    w_next_count;
    logic                w_range_hit;
    logic                w_dup_hit;
    logic                w_set_busy_hit;
    logic [RD_PORTS-1:0] w_rd_busy;

    // Out-of-range indices match no bit, so they simply drop out of the masks.
    always_comb begin
        w_range_hit = 1'b0;
        w_set_mask  = '0;
        w_clr_mask  = '0;
        for (int p = 0; p < SET_PORTS; p++) begin
            w_set_port[p] = '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (set_valid[p] && set_idx[p*IDX_W +: IDX_W] == IDX_W'(i))
                    w_set_port[p][i] = 1'b1;
            end
            if (ZERO_HARDWIRED != 0)
                w_set_port[p][0] = 1'b0;
            if (set_valid[p] && 32'(set_idx[p*IDX_W +: IDX_W]) >= NUM_REGS)
                w_range_hit = 1'b1;
            w_set_mask = w_set_mask | w_set_port[p];
        end
        for (int p = 0; p < CLR_PORTS; p++) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (clr_valid[p] && clr_idx[p*IDX_W +: IDX_W] == IDX_W'(i))
                    w_clr_mask[i] = 1'b1;
            end
            if (clr_valid[p] && 32'(clr_idx[p*IDX_W +: IDX_W]) >= NUM_REGS)
                w_range_hit = 1'b1;
        end
    end

    always_comb begin
        w_dup_hit = 1'b0;
        for (int p = 0; p < SET_PORTS; p++) begin
            for (int q = p + 1; q < SET_PORTS; q++) begin
                if (|(w_set_port[p] & w_set_port[q]))
                    w_dup_hit = 1'b1;
            end
        end
    end

    // Set wins over clear: a new producer overrides an older writeback.
    always_comb begin
        w_busy_next    = (r_busy_vec & ~w_clr_mask) | w_set_mask;
        w_set_busy_hit = |(w_set_mask & r_busy_vec & ~w_clr_mask);
        w_next_count   = '0;
        for (int i = 0; i < NUM_REGS; i++)
            w_next_count = w_next_count + CNT_W'(w_busy_next[i]);
    end

    always_comb begin
        w_rd_busy = '0;
        for (int r = 0; r < RD_PORTS; r++) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (rd_idx[r*IDX_W +: IDX_W] == IDX_W'(i))
                    w_rd_busy[r] = r_busy_vec[i] & ~w_clr_mask[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy_vec     <= '0;
            r_busy_count   <= '0;
            r_err_dup_set  <= 1'b0;
            r_err_set_busy <= 1'b0;
            r_err_range    <= 1'b0;
        end else if (flush) begin
            r_busy_vec     <= '0;
            r_busy_count   <= '0;
            r_err_dup_set  <= 1'b0;
            r_err_set_busy <= 1'b0;
            r_err_range    <= 1'b0;
        end else begin
            r_busy_vec     <= w_busy_next;
            r_busy_count   <= w_next_count;
            r_err_dup_set  <= r_err_dup_set  | w_dup_hit;
            r_err_set_busy <= r_err_set_busy | w_set_busy_hit;
            r_err_range    <= r_err_range    | w_range_hit;
        end
    end

    assign rd_busy      = w_rd_busy;
    assign busy_vec     = r_busy_vec;
    assign busy_count   = r_busy_count;
    assign err_dup_set  = r_err_dup_set;
    assign err_set_busy = r_err_set_busy;
    assign err_range    = r_err_range;

endmodule

// File: tb/tb_reg_busy_table.sv
// Bench for reg_busy_table: vector table, randomized run against a scoreboard model, and
// hand sequences for flush, out-of-range indices (24-register instance) and asynchronous reset.
module tb_reg_busy_table;

    logic        clk;
    logic        rst_n;

    logic        flush;
    logic [1:0]  set_valid;
    logic [9:0]  set_idx;
    logic [1:0]  clr_valid;
    logic [9:0]  clr_idx;
    logic [19:0] rd_idx;
    logic [3:0]  rd_busy;
    logic [31:0] busy_vec;
    logic [5:0]  busy_count;
    logic        err_dup_set, err_set_busy, err_range;

    logic        b_flush;
    logic [1:0]  b_set_valid;
    logic [9:0]  b_set_idx;
    logic [1:0]  b_clr_valid;
    logic [9:0]  b_clr_idx;
    logic [19:0] b_rd_idx;
    logic [3:0]  b_rd_busy;
    logic [23:0] b_busy_vec;
    logic [4:0]  b_busy_count;
    logic        b_err_dup_set, b_err_set_busy, b_err_range;

    reg_busy_table dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .set_valid(set_valid), .set_idx(set_idx),
        .clr_valid(clr_valid), .clr_idx(clr_idx),
        .rd_idx(rd_idx), .rd_busy(rd_busy),
        .busy_vec(busy_vec), .busy_count(busy_count),
        .err_dup_set(err_dup_set), .err_set_busy(err_set_busy), .err_range(err_range)
    );

    reg_busy_table #(.NUM_REGS(24)) dut24 (
        .clk(clk), .rst_n(rst_n), .flush(b_flush),
        .set_valid(b_set_valid), .set_idx(b_set_idx),
        .clr_valid(b_clr_valid), .clr_idx(b_clr_idx),
        .rd_idx(b_rd_idx), .rd_busy(b_rd_busy),
        .busy_vec(b_busy_vec), .busy_count(b_busy_count),
        .err_dup_set(b_err_dup_set), .err_set_busy(b_err_set_busy), .err_range(b_err_range)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        fl;
        logic [1:0]  sv;
        logic [4:0]  si0, si1;
        logic [1:0]  cv;
        logic [4:0]  ci0, ci1;
        logic [4:0]  r0, r1;
        logic [1:0]  exp_rd;
        logic [31:0] exp_busy;
        logic [5:0]  exp_cnt;
        logic [2:0]  exp_err;   // {dup_set, set_busy, range}
    } vec_t;

    localparam int NV = 13;
    vec_t tv [NV];

    // Reference model state for the randomized phase.
    bit m_busy [32];
    bit m_dup, m_sb;

    task automatic idle_inputs();
        flush = 1'b0; set_valid = '0; set_idx = '0; clr_valid = '0; clr_idx = '0; rd_idx = '0;
        b_flush = 1'b0; b_set_valid = '0; b_set_idx = '0; b_clr_valid = '0; b_clr_idx = '0; b_rd_idx = '0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;

        tv[0]  = '{1'b0, 2'b11, 5'd3,  5'd7,  2'b00, 5'd0,  5'd0,  5'd3,  5'd7,  2'b00, 32'h0000_0088, 6'd2, 3'b000};
        tv[1]  = '{1'b0, 2'b00, 5'd0,  5'd0,  2'b01, 5'd3,  5'd0,  5'd3,  5'd7,  2'b10, 32'h0000_0080, 6'd1, 3'b000};
        tv[2]  = '{1'b0, 2'b01, 5'd5,  5'd0,  2'b00, 5'd0,  5'd0,  5'd5,  5'd7,  2'b10, 32'h0000_00A0, 6'd2, 3'b000};
        tv[3]  = '{1'b0, 2'b01, 5'd5,  5'd0,  2'b10, 5'd0,  5'd5,  5'd5,  5'd7,  2'b10, 32'h0000_00A0, 6'd2, 3'b000};
        tv[4]  = '{1'b0, 2'b11, 5'd9,  5'd9,  2'b00, 5'd0,  5'd0,  5'd9,  5'd5,  2'b10, 32'h0000_02A0, 6'd3, 3'b100};
        tv[5]  = '{1'b0, 2'b00, 5'd0,  5'd0,  2'b00, 5'd0,  5'd0,  5'd9,  5'd0,  2'b01, 32'h0000_02A0, 6'd3, 3'b100};
        tv[6]  = '{1'b1, 2'b01, 5'd4,  5'd0,  2'b00, 5'd0,  5'd0,  5'd9,  5'd4,  2'b01, 32'h0000_0000, 6'd0, 3'b000};
        tv[7]  = '{1'b0, 2'b11, 5'd0,  5'd0,  2'b00, 5'd0,  5'd0,  5'd0,  5'd0,  2'b00, 32'h0000_0000, 6'd0, 3'b000};
        tv[8]  = '{1'b0, 2'b01, 5'd12, 5'd0,  2'b00, 5'd0,  5'd0,  5'd12, 5'd0,  2'b00, 32'h0000_1000, 6'd1, 3'b000};
        tv[9]  = '{1'b0, 2'b01, 5'd12, 5'd0,  2'b00, 5'd0,  5'd0,  5'd12, 5'd0,  2'b01, 32'h0000_1000, 6'd1, 3'b010};
        tv[10] = '{1'b0, 2'b00, 5'd0,  5'd0,  2'b11, 5'd12, 5'd12, 5'd12, 5'd0,  2'b00, 32'h0000_0000, 6'd0, 3'b010};
        tv[11] = '{1'b0, 2'b00, 5'd0,  5'd0,  2'b01, 5'd20, 5'd0,  5'd20, 5'd0,  2'b00, 32'h0000_0000, 6'd0, 3'b010};
        tv[12] = '{1'b0, 2'b11, 5'd31, 5'd1,  2'b00, 5'd0,  5'd0,  5'd31, 5'd1,  2'b00, 32'h8000_0002, 6'd2, 3'b010};

        // Reset state, sampled while reset is held.
        #3;
        check("reset busy_vec", 64'(busy_vec), 64'h0);
        check("reset busy_count", 64'(busy_count), 64'h0);
        check("reset errs", 64'({err_dup_set, err_set_busy, err_range}), 64'h0);
        check("reset rd_busy", 64'(rd_busy), 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < NV; k++) begin
            flush     = tv[k].fl;
            set_valid = tv[k].sv;
            set_idx   = {tv[k].si1, tv[k].si0};
            clr_valid = tv[k].cv;
            clr_idx   = {tv[k].ci1, tv[k].ci0};
            rd_idx    = {5'd0, 5'd0, tv[k].r1, tv[k].r0};
            #2;
            check($sformatf("vec%0d rd_busy", k), 64'(rd_busy), 64'({2'b00, tv[k].exp_rd}));
            @(posedge clk); #1;
            check($sformatf("vec%0d busy_vec", k), 64'(busy_vec), 64'(tv[k].exp_busy));
            check($sformatf("vec%0d busy_count", k), 64'(busy_count), 64'(tv[k].exp_cnt));
            check($sformatf("vec%0d errs", k), 64'({err_dup_set, err_set_busy, err_range}), 64'(tv[k].exp_err));
        end
        idle_inputs();

        // Sticky error survives idle cycles, then flush clears it.
        repeat (3) @(posedge clk);
        #1;
        check("sticky set_busy", 64'(err_set_busy), 64'h1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush errs", 64'({err_dup_set, err_set_busy, err_range}), 64'h0);
        check("flush busy_vec", 64'(busy_vec), 64'h0);

        // Randomized run against the scoreboard model.
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_dup = 1'b0; m_sb = 1'b0;
        for (int c = 0; c < 300; c++) begin
            int si [2];
            int ci [2];
            int ri [4];
            bit sv [2];
            bit cv [2];
            bit fl;
            bit freeing [32];
            bit claiming [32];
            logic [3:0]  e_rd;
            logic [31:0] e_busy;
            int          e_cnt;
            bit          dup_now, sb_now;

            fl = ($urandom_range(0, 15) == 0);
            for (int p = 0; p < 2; p++) begin
                sv[p] = 1'($urandom_range(0, 1));
                cv[p] = 1'($urandom_range(0, 1));
                si[p] = $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31);
                ci[p] = $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31);
            end
            for (int r = 0; r < 4; r++)
                ri[r] = $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31);

            flush     = fl;
            set_valid = {sv[1], sv[0]};
            set_idx   = {5'(si[1]), 5'(si[0])};
            clr_valid = {cv[1], cv[0]};
            clr_idx   = {5'(ci[1]), 5'(ci[0])};
            rd_idx    = {5'(ri[3]), 5'(ri[2]), 5'(ri[1]), 5'(ri[0])};

            foreach (freeing[i]) begin
                freeing[i]  = 1'b0;
                claiming[i] = 1'b0;
            end
            for (int p = 0; p < 2; p++) begin
                if (cv[p]) freeing[ci[p]] = 1'b1;
                if (sv[p] && si[p] != 0) claiming[si[p]] = 1'b1;
            end
            for (int r = 0; r < 4; r++)
                e_rd[r] = m_busy[ri[r]] && !freeing[ri[r]];
            dup_now = sv[0] && sv[1] && si[0] == si[1] && si[0] != 0;
            sb_now  = 1'b0;
            for (int i = 0; i < 32; i++)
                if (claiming[i] && m_busy[i] && !freeing[i]) sb_now = 1'b1;

            #2;
            check($sformatf("rnd%0d rd_busy", c), 64'(rd_busy), 64'(e_rd));

            if (fl) begin
                foreach (m_busy[i]) m_busy[i] = 1'b0;
                m_dup = 1'b0; m_sb = 1'b0;
            end else begin
                foreach (m_busy[i]) m_busy[i] = claiming[i] || (m_busy[i] && !freeing[i]);
                m_dup = m_dup || dup_now;
                m_sb  = m_sb || sb_now;
            end
            e_cnt = 0;
            for (int i = 0; i < 32; i++) begin
                e_busy[i] = m_busy[i];
                e_cnt += int'(m_busy[i]);
            end

            @(posedge clk); #1;
            check($sformatf("rnd%0d busy_vec", c), 64'(busy_vec), 64'(e_busy));
            check($sformatf("rnd%0d busy_count", c), 64'(busy_count), 64'(e_cnt));
            check($sformatf("rnd%0d errs", c), 64'({err_dup_set, err_set_busy, err_range}),
                  64'({m_dup, m_sb, 1'b0}));
        end
        idle_inputs();

        // 24-register instance: in-range set, then out-of-range set.
        b_set_valid = 2'b01;
        b_set_idx   = {5'd0, 5'd3};
        set_valid   = 2'b01;
        set_idx     = {5'd0, 5'd2};
        @(posedge clk); #1;
        set_valid = '0;
        rd_idx    = {15'd0, 5'd2};
        check("n24 busy_vec set3", 64'(b_busy_vec), 64'h8);
        check("n24 busy_count set3", 64'(b_busy_count), 64'h1);
        check("n24 err_range clean", 64'(b_err_range), 64'h0);
        b_set_idx = {5'd0, 5'd30};
        b_rd_idx  = {10'd0, 5'd30, 5'd3};
        #2;
        check("n24 rd_busy oor", 64'(b_rd_busy), 64'h1);
        @(posedge clk); #1;
        b_set_valid = '0;
        check("n24 busy_vec after oor", 64'(b_busy_vec), 64'h8);
        check("n24 busy_count after oor", 64'(b_busy_count), 64'h1);
        check("n24 err_range", 64'(b_err_range), 64'h1);
        check("n24 no dup", 64'(b_err_dup_set), 64'h0);
        @(posedge clk); #1;
        check("n24 err_range sticky", 64'(b_err_range), 64'h1);

        // Asynchronous reset mid-cycle with live state and active inputs.
        check("pre-reset a rd_busy", 64'(rd_busy[0]), 64'h1);
        check("pre-reset b rd_busy", 64'(b_rd_busy[0]), 64'h1);
        set_valid   = 2'b11;
        set_idx     = {5'd6, 5'd8};
        b_set_valid = 2'b01;
        b_set_idx   = {5'd0, 5'd9};
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst a busy_vec", 64'(busy_vec), 64'h0);
        check("async rst a busy_count", 64'(busy_count), 64'h0);
        check("async rst a errs", 64'({err_dup_set, err_set_busy, err_range}), 64'h0);
        check("async rst a rd_busy", 64'(rd_busy), 64'h0);
        check("async rst b busy_vec", 64'(b_busy_vec), 64'h0);
        check("async rst b busy_count", 64'(b_busy_count), 64'h0);
        check("async rst b errs", 64'({b_err_dup_set, b_err_set_busy, b_err_range}), 64'h0);
        check("async rst b rd_busy", 64'(b_rd_busy), 64'h0);
        @(posedge clk); #1;
        check("held rst a busy_vec", 64'(busy_vec), 64'h0);
        idle_inputs();
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_busy_table.md
Name: reg_busy_table

Overview:
Parametrised register-scoreboard that generalises the two-enable write-index decoder into a stateful busy-bit table. Issue stage marks destination registers busy through SET_PORTS one-hot-decoded set ports. Writeback marks them free through CLR_PORTS decoded clear ports. Operand-check logic queries busy state through RD_PORTS read ports, with same-cycle clear bypass.

Parameters:
NUM_REGS, 32, number of architectural registers tracked
IDX_W, $clog2(NUM_REGS), register index width
SET_PORTS, 2, number of issue (set) ports
CLR_PORTS, 2, number of writeback (clear) ports
RD_PORTS, 4, number of busy query ports
ZERO_HARDWIRED, 1, when 1 register 0 is never marked busy

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  clears all busy bits and sticky errors
set_valid  in  SET_PORTS  per-port set enable
set_idx  in  SET_PORTS*IDX_W  per-port destination index, port p at [p*IDX_W +: IDX_W]
clr_valid  in  CLR_PORTS  per-port clear enable
clr_idx  in  CLR_PORTS*IDX_W  per-port writeback index
rd_idx  in  RD_PORTS*IDX_W  query indices
rd_busy  out  RD_PORTS  combinational busy result per query
busy_vec  out  NUM_REGS  registered busy bits
busy_count  out  $clog2(NUM_REGS+1)  registered popcount of busy_vec
err_dup_set  out  1  sticky: two set ports hit the same index in one cycle
err_set_busy  out  1  sticky: set applied to an already-busy register not cleared that cycle
err_range  out  1  sticky: any valid index >= NUM_REGS

Behaviour:
- Reset (rst_n=0, async): busy_vec=0, busy_count=0, all err_* =0. rd_busy=0 while in reset.
- Decode per port: set_mask_p[i] = set_valid[p] & (set_idx_p==i) for i<NUM_REGS. clr_mask_p is decoded the same way. set_mask = OR over all set ports; clr_mask = OR over all clear ports.
- Out-of-range index (>= NUM_REGS, possible when NUM_REGS is not a power of 2): decodes to no bit and sets err_range on the next edge.
- ZERO_HARDWIRED=1: bit 0 of set_mask is forced to 0, so busy_vec[0] is always 0. Set-port hits on register 0 raise no error.
- Next state: busy_next = (busy_vec & ~clr_mask) | set_mask.
  - Set wins over clear for the same register in the same cycle: a new producer overrides an old writeback.
  - Update takes effect on the next rising edge (1-cycle latency to busy_vec).
- flush=1: on the next edge busy_vec=0 and all err_* =0, overriding any same-cycle set or clear. Errors detected in a flush cycle are discarded.
- rd_busy[r] = busy_vec[rd_idx_r] & ~clr_mask[rd_idx_r].
  - Same-cycle clear bypass: a register being written back reads not-busy.
  - Same-cycle sets are NOT visible on rd_busy.
  - Out-of-range rd_idx reads 0.
  - Register 0 reads 0 when ZERO_HARDWIRED=1.
- err_dup_set: set at the edge if any two set ports are valid with equal in-range index. Register 0 is excluded when ZERO_HARDWIRED=1. Sticky until flush or reset.
- err_set_busy: set if set_mask[i] & busy_vec[i] & ~clr_mask[i] for any i. Sticky until flush or reset.
- Two clear ports on the same index: legal, no error.
- Clear of a non-busy register: legal no-op, no error.
- busy_count: registered together with busy_vec, equal to the popcount of busy_next. Range 0..NUM_REGS.
- No handshake and no backpressure: every valid request is applied in its cycle.
- Reset asserted mid-operation clears everything immediately, regardless of inputs.

Test Plan:
- Reset, then set_valid=2'b11, set_idx={5'd7,5'd3} -> next cycle busy_vec=32'h0000_0088, busy_count=2, no errors.
- busy_vec bits 3 and 7 set; clr_valid[0]=1, clr_idx=3, rd_idx0=3, rd_idx1=7 in the same cycle -> rd_busy[0]=0 (bypass), rd_busy[1]=1; next cycle busy_vec=32'h80, busy_count=1.
- Reg 5 busy; same cycle set port0 idx=5 and clear port1 idx=5 -> busy_vec[5] stays 1, err_set_busy stays 0.
- Set port0 and port1 both idx=9 -> busy_vec[9]=1, err_dup_set=1 and holds across later idle cycles. Then flush=1 with set port0 idx=4 -> busy_vec=0, err_dup_set=0.
- ZERO_HARDWIRED=1, set idx=0 on both ports -> busy_vec[0]=0, no errors, rd_busy for idx 0 = 0.
- NUM_REGS=24 instance: set idx=30 -> busy_vec unchanged, err_range=1. Assert rst_n=0 mid-cycle -> all outputs 0 immediately, without waiting for a clock edge.
